// File: rtl/console_ser_emulator_if.sv
// Bundles the console pins, the controller button bus and the poll status
// between the controller side (master) and the serial emulator (slave).
interface console_ser_emulator_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int POLL_CNT_W  = 16
);

  logic                      mode;
  logic [NUM_PLAYERS*12-1:0] buttons;
  logic                      ser_latch;
  logic [NUM_PLAYERS-1:0]    ser_clk;
  logic [NUM_PLAYERS-1:0]    ser_data;
  logic                      poll_strobe;
  logic [POLL_CNT_W-1:0]     poll_count;

  modport master (
    output mode,
    output buttons,
    output ser_latch,
    output ser_clk,
    input  ser_data,
    input  poll_strobe,
    input  poll_count
  );

  modport slave (
    input  mode,
    input  buttons,
    input  ser_latch,
    input  ser_clk,
    output ser_data,
    output poll_strobe,
    output poll_count
  );

endinterface

// File: rtl/console_ser_emulator.sv
// NES/SNES controller shift-register emulator for NUM_PLAYERS ports.
// The console latch and per-port serial clocks are asynchronous.
// They are synchronised, then edge-detected.
// Each port then shifts its own active-low frame out on a registered data pin.
module console_ser_emulator #(
  parameter int NUM_PLAYERS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int POLL_CNT_W  = 16
) (
  input logic                   clk,
  input logic                   reset,
  console_ser_emulator_if.slave bus
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] IDX_EXHAUSTED = IDX_W'(16);
  localparam logic [IDX_W-1:0] LEN_NES       = IDX_W'(8);
  localparam logic [IDX_W-1:0] LEN_SNES      = IDX_W'(16);

  // Builds the active-low serial frame for one player.
  // Bit 0 is shifted out first.
  // Unused tail positions read as released (1).
  function automatic logic [15:0] buildFrame(input logic [11:0] b, input logic isSnes);
    logic [15:0] f;
    if (isSnes) begin
      f = {4'hF, ~b[11], ~b[10], ~b[8], ~b[6],
           ~b[3], ~b[2], ~b[1], ~b[0], ~b[4], ~b[5], ~b[9], ~b[7]};
    end else begin
      f = {8'hFF, ~b[3], ~b[2], ~b[1], ~b[0], ~b[4], ~b[5], ~b[7], ~b[6]};
    end
    return f;
  endfunction

  logic [SYNC_STAGES-1:0] r_latchSync;
  logic                   r_latchPrev;
  logic [SYNC_STAGES-1:0] r_clkSync [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_clkPrev;

  logic                   r_frameMode;
  logic                   r_pollStrobe;
  logic [POLL_CNT_W-1:0]  r_pollCount;

  logic [15:0]            r_frame   [NUM_PLAYERS];
  logic [IDX_W-1:0]       r_index   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_serData;

  logic                   w_latchLevel;
  logic                   w_latchRise;
  logic [NUM_PLAYERS-1:0] w_clkRise;
  logic                   w_loadMode;
  logic [IDX_W-1:0]       w_frameLen;
  logic [15:0]            w_loadFrame [NUM_PLAYERS];
  logic [IDX_W-1:0]       w_nextIdx   [NUM_PLAYERS];

  // Synchroniser chains plus one history flop per console input for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latchSync <= '0;
      r_latchPrev <= 1'b0;
      r_clkPrev   <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_clkSync[p] <= '0;
      end
    end else begin
      r_latchSync <= {r_latchSync[SYNC_STAGES-2:0], bus.ser_latch};
      r_latchPrev <= r_latchSync[SYNC_STAGES-1];
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_clkSync[p] <= {r_clkSync[p][SYNC_STAGES-2:0], bus.ser_clk[p]};
        r_clkPrev[p] <= r_clkSync[p][SYNC_STAGES-1];
      end
    end
  end

  assign w_latchLevel = r_latchSync[SYNC_STAGES-1];
  assign w_latchRise  = w_latchLevel & ~r_latchPrev;

  // A reload on the rising latch edge takes the live mode.
  // Reloads while the latch is held use the mode captured at that edge.
  assign w_loadMode = w_latchRise ? bus.mode : r_frameMode;
  assign w_frameLen = r_frameMode ? LEN_SNES : LEN_NES;

  // Per-port rising-edge detect, candidate next index and reload frame.
  always_comb begin
    w_clkRise = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_clkRise[p]   = r_clkSync[p][SYNC_STAGES-1] & ~r_clkPrev[p];
      w_nextIdx[p]   = r_index[p] + IDX_W'(1);
      w_loadFrame[p] = buildFrame(bus.buttons[12*p +: 12], w_loadMode);
    end
  end

  // Captures the frame mode, counts polls and raises a one-cycle strobe on each latch edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameMode  <= 1'b0;
      r_pollStrobe <= 1'b0;
      r_pollCount  <= '0;
    end else begin
      r_pollStrobe <= w_latchRise;
      if (w_latchRise) begin
        r_frameMode <= bus.mode;
        r_pollCount <= r_pollCount + POLL_CNT_W'(1);
      end
    end
  end

  // A held latch keeps every port parallel-loading and parked on bit 0.
  // Otherwise each port shifts on its own clock edge and saturates past the frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_serData <= '1;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_frame[p] <= '1;
        r_index[p] <= IDX_EXHAUSTED;
      end
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_latchLevel) begin
          r_frame[p]   <= w_loadFrame[p];
          r_index[p]   <= '0;
          r_serData[p] <= w_loadFrame[p][0];
        end else if (w_clkRise[p]) begin
          if (w_nextIdx[p] < w_frameLen) begin
            r_index[p]   <= w_nextIdx[p];
            r_serData[p] <= r_frame[p][w_nextIdx[p][3:0]];
          end else begin
            r_index[p]   <= w_frameLen;
            r_serData[p] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ser_data    = r_serData;
  assign bus.poll_strobe = r_pollStrobe;
  assign bus.poll_count  = r_pollCount;

endmodule

// File: tb/tb_console_ser_emulator.sv
// Directed and randomised bench for console_ser_emulator.
// Expected serial data comes from a frame model built from the button order tables.
module tb_console_ser_emulator;

  localparam int NP = 2;
  localparam int SS = 2;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;

  // Free-running system clock.
  always #5 clk = ~clk;

  console_ser_emulator_if #(.NUM_PLAYERS(NP), .POLL_CNT_W(PW)) bus ();

  console_ser_emulator #(
    .NUM_PLAYERS(NP),
    .SYNC_STAGES(SS),
    .POLL_CNT_W (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  int   mPos   [NP];
  int   mLen;
  logic mFrame [NP][16];
  int   mCount;

  // Serial bit i of a frame, taken from the console's button order tables.
  function automatic logic modelBit(input logic [11:0] b, input logic snes, input int i);
    int nesOrder[8]   = '{6, 7, 5, 4, 0, 1, 2, 3};
    int snesOrder[12] = '{7, 9, 5, 4, 0, 1, 2, 3, 6, 8, 10, 11};
    if (!snes) return (i < 8) ? ~b[nesOrder[i]] : 1'b1;
    return (i < 12) ? ~b[snesOrder[i]] : 1'b1;
  endfunction

  // Model pin value for every port.
  function automatic logic [NP-1:0] expectedData();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = (mPos[p] < mLen) ? mFrame[p][mPos[p]] : 1'b1;
    return v;
  endfunction

  // Captures fresh frames into the model, as a console latch does.
  task automatic modelLoad();
    mLen = bus.mode ? 16 : 8;
    for (int p = 0; p < NP; p++) begin
      mPos[p] = 0;
      for (int i = 0; i < 16; i++) mFrame[p][i] = modelBit(bus.buttons[12*p +: 12], bus.mode, i);
    end
  endtask

  // Returns the model to its post-reset state.
  task automatic modelReset();
    mLen   = 8;
    mCount = 0;
    for (int p = 0; p < NP; p++) mPos[p] = 16;
  endtask

  // Advances by n clocks and leaves the sample point just after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compares one observed value with its expected value and counts the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the controller-side mode and button bus.
  task automatic applyStimulus(input logic m, input logic [NP*12-1:0] b);
    bus.mode    = m;
    bus.buttons = b;
  endtask

  // Full latch pulse, with checks on the strobe width, poll count and first bit.
  task automatic latchPulse(input string tag);
    int seen = 0;
    modelLoad();
    bus.ser_latch = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen += int'(bus.poll_strobe);
    end
    bus.ser_latch = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen += int'(bus.poll_strobe);
    end
    mCount = (mCount + 1) % (1 << PW);
    checkOutput({tag, "_strobe"}, seen, 1);
    checkOutput({tag, "_count"}, 32'(bus.poll_count), mCount);
    checkOutput({tag, "_bit0"}, 32'(bus.ser_data), 32'(expectedData()));
  endtask

  // Short latch pulse with no checks, used to walk the poll counter.
  task automatic quickLatch();
    bus.ser_latch = 1'b1;
    tick(3);
    bus.ser_latch = 1'b0;
    tick(3);
    mCount = (mCount + 1) % (1 << PW);
  endtask

  // One serial clock pulse on the masked ports, with a check of both data pins.
  task automatic clkPulse(input string tag, input logic [NP-1:0] mask);
    bus.ser_clk = bus.ser_clk | mask;
    tick(6);
    bus.ser_clk = bus.ser_clk & ~mask;
    tick(6);
    for (int p = 0; p < NP; p++) if (mask[p] && mPos[p] < mLen) mPos[p]++;
    checkOutput(tag, 32'(bus.ser_data), 32'(expectedData()));
  endtask

  // Directed sequence followed by randomised frames.
  initial begin
    logic [NP-1:0] mask;
    int nclk;

    reset         = 1'b1;
    bus.ser_latch = 1'b0;
    bus.ser_clk   = '0;
    applyStimulus(1'b0, '0);
    modelReset();
    tick(3);
    checkOutput("reset_data", 32'(bus.ser_data), 32'(2'b11));
    checkOutput("reset_count", 32'(bus.poll_count), 0);
    checkOutput("reset_strobe", 32'(bus.poll_strobe), 0);
    reset = 1'b0;
    tick(2);

    $display("[TB] serial clocks with no latch");
    for (int i = 0; i < 20; i++) clkPulse("nolatch", 2'b11);

    $display("[TB] NES frame on port 0");
    applyStimulus(1'b0, {12'h000, 12'h041});
    latchPulse("nes");
    for (int i = 0; i < 12; i++) clkPulse("nes_shift", 2'b01);

    $display("[TB] SNES frame on port 1");
    applyStimulus(1'b1, {12'hC80, 12'h000});
    latchPulse("snes");
    for (int i = 0; i < 18; i++) clkPulse("snes_shift", 2'b11);

    $display("[TB] live reload while latch held");
    applyStimulus(1'b0, '0);
    bus.ser_latch = 1'b1;
    tick(6);
    applyStimulus(1'b0, {12'h000, 12'h040});
    tick(SS + 2);
    modelLoad();
    mCount = (mCount + 1) % (1 << PW);
    checkOutput("reload_live", 32'(bus.ser_data[0]), 0);
    bus.ser_latch = 1'b0;
    tick(SS + 2);
    applyStimulus(1'b0, '0);
    tick(4);
    checkOutput("reload_hold", 32'(bus.ser_data), 32'(expectedData()));
    checkOutput("reload_count", 32'(bus.poll_count), mCount);

    $display("[TB] mode change mid-frame, then re-latch");
    applyStimulus(1'b1, {12'h5A3, 12'hC80});
    latchPulse("midmode");
    for (int i = 0; i < 5; i++) clkPulse("midmode_a", 2'b11);
    applyStimulus(1'b0, {12'h5A3, 12'hC80});
    for (int i = 0; i < 12; i++) clkPulse("midmode_b", 2'b11);
    latchPulse("relatch");
    for (int i = 0; i < 10; i++) clkPulse("relatch_shift", 2'b11);

    $display("[TB] latch and serial clock rising together");
    applyStimulus(1'b0, {12'h0C0, 12'h041});
    modelLoad();
    bus.ser_latch = 1'b1;
    bus.ser_clk   = 2'b11;
    tick(6);
    bus.ser_latch = 1'b0;
    bus.ser_clk   = 2'b00;
    tick(6);
    mCount = (mCount + 1) % (1 << PW);
    checkOutput("same_edge", 32'(bus.ser_data), 32'(expectedData()));

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, {12'h000, 12'h010});
    latchPulse("rstframe");
    for (int i = 0; i < 3; i++) clkPulse("rstframe_shift", 2'b01);
    checkOutput("rstframe_start", 32'(bus.ser_data[0]), 0);
    reset = 1'b1;
    tick(1);
    modelReset();
    checkOutput("midreset_data", 32'(bus.ser_data), 32'(2'b11));
    checkOutput("midreset_count", 32'(bus.poll_count), 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    clkPulse("midreset_shift", 2'b11);

    $display("[TB] poll counter wrap");
    for (int i = 0; i < (1 << PW) - 1; i++) quickLatch();
    tick(2);
    checkOutput("count_full", 32'(bus.poll_count), (1 << PW) - 1);
    applyStimulus(1'b0, '0);
    latchPulse("wrap");

    $display("[TB] randomised frames");
    for (int f = 0; f < 8; f++) begin
      applyStimulus(1'($urandom_range(0, 1)), (NP*12)'($urandom));
      latchPulse("rand_latch");
      nclk = $urandom_range(4, 20);
      for (int i = 0; i < nclk; i++) begin
        if (i == 3) applyStimulus(1'($urandom_range(0, 1)), (NP*12)'($urandom));
        mask = NP'($urandom_range(1, 3));
        clkPulse("rand_shift", mask);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/console_ser_emulator.md
Name: console_ser_emulator

Overview:
- Parametrised successor to the per-console parallel-to-serial blocks: one block emulates NES (8-bit frame) or SNES (16-bit frame) controller shift registers for NUM_PLAYERS ports.
- Console latch/clock are asynchronous. They are synchronised into the system clock and edge-detected, and each port's serial data is driven from a registered shift path.
- Sits between controller_SM player outputs and the console connector pins.

Parameters:
- NUM_PLAYERS, 2, number of controller ports emulated (1..4).
- SYNC_STAGES, 2, synchroniser flops on each console input (>=2).
- POLL_CNT_W, 16, width of poll_count.

Ports:
- clk  input  1  system clock; must be >= 8x the fastest console serial clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = NES 8-bit frame, 1 = SNES 16-bit frame.
- buttons  input  NUM_PLAYERS*12  active-high pressed, 12 bits per player p at [12p+11:12p]. Bit order: 0 up, 1 down, 2 left, 3 right, 4 start, 5 select, 6 A, 7 B, 8 X, 9 Y, 10 L, 11 R.
- ser_latch  input  1  console latch, shared by all ports, asynchronous.
- ser_clk  input  NUM_PLAYERS  console serial clock per port, asynchronous.
- ser_data  output  NUM_PLAYERS  serial data per port, active-low (pressed = 0).
- poll_strobe  output  1  one-clk pulse on each synced latch rising edge.
- poll_count  output  POLL_CNT_W  number of latch rising edges since reset, wraps.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - ser_data all 1; poll_strobe 0; poll_count 0.
  - Per-port bit index = 16 (exhausted).
  - Synchroniser and edge-detect history flops cleared to 0.
- Synchronisation:
  - ser_latch and each ser_clk[p] pass SYNC_STAGES flops, then a 1-flop edge detector.
  - Rising edge is seen SYNC_STAGES+1 clk cycles after the pin edge.
- Frame contents (stored active-low internally, pressed -> 0):
  - NES, serial order A, B, Select, Start, Up, Down, Left, Right. Length 8.
  - SNES, serial order B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then four 1s. Length 16.
- Latch handling:
  - On the synced latch rising edge: mode is sampled into frame_mode. Every port loads its frame from buttons and sets index 0. ser_data[p] shows bit 0 on the next clk. poll_strobe pulses for 1 cycle. poll_count increments (wraps at all-ones -> 0).
  - While synced latch stays high, every clk reloads the frames from live buttons (4021 parallel-load behaviour). Index stays 0.
- Shift handling, per port, independent:
  - A synced ser_clk[p] rising edge while synced latch is low increments index.
  - If the new index < frame length: ser_data[p] = frame bit[index].
  - Otherwise index saturates at frame length and ser_data[p] = 1.
  - Clock edges while latch is high are ignored.
  - Falling edges of ser_clk do nothing.
- Boundaries:
  - Extra clocks after the frame ends: ser_data stays 1. No wrap-around to bit 0.
  - mode change mid-frame: no effect until the next latch rising edge.
  - buttons change mid-frame: no effect on the shifting frame. Only a latch reload captures it.
  - Latch rising edge and ser_clk rising edge detected in the same clk: the latch wins; index = 0.
  - Reset mid-frame: ser_data returns to 1 on the next clk and all in-flight frames are discarded.
- Output latency: ser_data[p] is valid <= SYNC_STAGES+2 clk after the corresponding console edge.

Test Plan:
- Reset: assert reset 3 clk -> ser_data=all 1, poll_count=0, poll_strobe=0. 20 ser_clk pulses with no latch -> ser_data stays 1.
- NES frame: mode=0, P0 buttons=12'h041 (A+up), latch pulse, 8 ser_clk pulses -> ser_data[0] sequence 0,1,1,1,0,1,1,1, then 1 on pulses 9-12. poll_count=1, poll_strobe high exactly 1 clk.
- SNES frame: mode=1, P1 buttons=12'hC80 (B+L+R), latch, 16 clocks -> ser_data[1] sequence 0,1,1,1,1,1,1,1,1,1,0,0,1,1,1,1. P0 (buttons=0) all 1s.
- Live reload: hold latch high, change P0 from 0 to A pressed -> ser_data[0]=0 within SYNC_STAGES+2 clk. Drop latch, then change buttons to 0 -> bit 0 still 0.
- Mid-frame mode/latch: SNES frame after 5 clocks, set mode=0, continue -> SNES bits continue. Re-latch -> index 0; next frame is 8 bits, then 1s.
- Reset mid-frame after 3 shifts -> ser_data=1 next clk. poll_count wraps from 16'hFFFF to 0 on the next latch (preload via 65536 latches or force).
